// File: rtl/otter_lsu.sv
// Load/store initiator for the OTTER memory data port (ADDR2 side): one request in flight,
// address/size/sign held through the read window. Optional misalignment trap: OTTER_LSU_MISALIGN_TRAP_EN.
module otter_lsu #(
  parameter int          MEM_LAT = 1,
  parameter logic [31:0] IO_BASE = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        RSP_IO,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt;
  logic       op_we;
  logic       accept;
  logic       reject;

  assign REQ_READY = (state == IDLE);
  assign accept    = REQ_VALID && REQ_READY;

`ifdef OTTER_LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (REQ_SIZE)
      2'd0:    reject = 1'b0;
      2'd1:    reject = (REQ_ADDR[1:0] == 2'b11);
      2'd2:    reject = (REQ_ADDR[1:0] != 2'b00);
      default: reject = 1'b1;
    endcase
  end
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch would infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = reject ? RESP : ISSUE;
      ISSUE:   state_nxt = op_we ? RESP : WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_nxt = RESP;
      RESP:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_WE2   <= 1'b0;
      MEM_RDEN2 <= 1'b0;
      MEM_ADDR2 <= '0;
      MEM_DIN2  <= '0;
      MEM_SIZE  <= '0;
      MEM_SIGN  <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      RSP_IO    <= 1'b0;
      op_we     <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; the enables default low so they pulse for one cycle only.
      MEM_WE2   <= 1'b0;
      MEM_RDEN2 <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          MEM_ADDR2 <= REQ_ADDR;
          MEM_DIN2  <= REQ_WDATA;
          MEM_SIZE  <= REQ_SIZE;
          MEM_SIGN  <= REQ_SIGN;
          op_we     <= REQ_WE;
          RSP_IO    <= (REQ_ADDR >= IO_BASE);
          RSP_ERR   <= reject;
          RSP_RDATA <= '0;
          if (reject) begin
            RSP_VALID <= 1'b1;
          end else begin
            MEM_WE2   <= REQ_WE;
            MEM_RDEN2 <= !REQ_WE;
          end
        end
        ISSUE: begin
          if (op_we) RSP_VALID <= 1'b1;
          else       lat_cnt   <= LAT_INIT;
        end
        WAIT: begin
          // The memory sizes/extends combinationally from MEM_ADDR2/SIZE/SIGN, so these stay put here.
          if (lat_cnt == 3'd0) begin
            RSP_RDATA <= MEM_DOUT2;
            RSP_VALID <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: if (RSP_READY) RSP_VALID <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// Self-checking bench for otter_lsu: byte-addressed memory model, word-level reference model,
// random legal traffic plus directed scenarios (backpressure, MMIO, misalign, reset, latency).
module tb_otter_lsu;

  logic        clk, rst_n;
  logic        req_valid, req_valid3, req_ready, req_ready_3;
  logic        req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_ready;
  logic        rsp_valid, rsp_err, rsp_io, rsp_valid_3, rsp_err_3, rsp_io_3;
  logic [31:0] rsp_rdata, rsp_rdata_3;
  logic        mem_rden2, mem_we2, mem_sign, mem_rden2_3, mem_we2_3, mem_sign_3;
  logic [31:0] mem_addr2, mem_din2, mem_dout2, mem_addr2_3, mem_din2_3, mem_dout2_3;
  logic [1:0]  mem_size, mem_size_3;

  int n_checks = 0;
  int n_pass   = 0;
  int we_pulses = 0;
  int rd_pulses = 0;
  int cyc = 0;

  otter_lsu #(.MEM_LAT(1), .IO_BASE(32'h0001_0000)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_SIZE(req_size), .REQ_SIGN(req_sign),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .RSP_IO(rsp_io), .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2),
    .MEM_DIN2(mem_din2), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout2)
  );

  otter_lsu #(.MEM_LAT(3), .IO_BASE(32'h0001_0000)) dut3 (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid3), .REQ_READY(req_ready_3), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_SIZE(req_size), .REQ_SIGN(req_sign),
    .RSP_VALID(rsp_valid_3), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata_3), .RSP_ERR(rsp_err_3),
    .RSP_IO(rsp_io_3), .MEM_RDEN2(mem_rden2_3), .MEM_WE2(mem_we2_3), .MEM_ADDR2(mem_addr2_3),
    .MEM_DIN2(mem_din2_3), .MEM_SIZE(mem_size_3), .MEM_SIGN(mem_sign_3), .MEM_DOUT2(mem_dout2_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment (byte array, sizes/extends like the OTTER memory)
  logic [7:0]  mem [0:4095];
  logic [11:0] wi;
  logic [31:0] pend3;
  int          cnt3 = -1;
  assign wi = mem_addr2[11:0];

  function automatic logic [31:0] mem_read(logic [31:0] a, logic [1:0] sz, logic uns);
    logic [11:0] i;
    logic [7:0]  b0, b1, b2, b3;
    i  = a[11:0];
    b0 = mem[i];
    b1 = mem[i + 12'd1];
    b2 = mem[i + 12'd2];
    b3 = mem[i + 12'd3];
    case (sz)
      2'd0:    return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (mem_we2) begin
      we_pulses++;
      mem[wi] <= mem_din2[7:0];
      if (mem_size != 2'd0) mem[wi + 12'd1] <= mem_din2[15:8];
      if (mem_size[1]) begin
        mem[wi + 12'd2] <= mem_din2[23:16];
        mem[wi + 12'd3] <= mem_din2[31:24];
      end
    end
    if (mem_rden2) begin
      rd_pulses++;
      mem_dout2 <= mem_read(mem_addr2, mem_size, mem_sign);
    end
  end

  // Three-cycle memory for dut3: wrong data until the latency has elapsed.
  always @(posedge clk) begin
    if (mem_rden2_3) begin
      pend3       <= mem_read(mem_addr2_3, mem_size_3, mem_sign_3);
      mem_dout2_3 <= ~mem_read(mem_addr2_3, mem_size_3, mem_sign_3);
      cnt3        <= 1;
    end else if (cnt3 > 0) begin
      cnt3 <= cnt3 - 1;
    end else if (cnt3 == 0) begin
      mem_dout2_3 <= pend3;
      cnt3        <= -1;
    end
  end

  // ---------------- reference model (word array, arithmetic extraction)
  logic [31:0] ref_words [0:1023];

  function automatic logic [31:0] exp_load(logic [31:0] a, logic [1:0] sz, logic uns);
    longint w, v;
    w = longint'(ref_words[a[11:2]]);
    v = w >> (8 * a[1:0]);
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    longint w, m;
    int     sh;
    sh = 8 * a[1:0];
    m  = (sz == 2'd0) ? 255 : (sz == 2'd1) ? 65535 : 64'hFFFF_FFFF;
    w  = longint'(ref_words[a[11:2]]);
    w  = (w & ~(m << sh)) | ((longint'(d) & m) << sh);
    ref_words[a[11:2]] = w[31:0];
  endtask

  // ---------------- transaction driver (returns observations only)
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sign, input int hold,
                         output int lat, output logic [31:0] rdata, output logic err, output logic io,
                         output int we_p, output int rd_p, output bit addr_ok, output bit stable_ok,
                         output bit idle_ok, output bit tmo);
    int w0, r0, guard;
    w0 = we_pulses;
    r0 = rd_pulses;
    addr_ok = 1'b1;
    stable_ok = 1'b1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_sign = sign;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_sign = 1'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (mem_addr2 !== addr) addr_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (mem_addr2 !== addr) addr_ok = 1'b0;
    tmo = !rsp_valid;
    rdata = rsp_rdata; err = rsp_err; io = rsp_io;
    for (int k = 0; k < hold; k++) begin
      if (!rsp_valid || req_ready || rsp_rdata !== rdata || mem_rden2 || mem_we2) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    idle_ok = req_ready && !rsp_valid;
    we_p = we_pulses - w0;
    rd_p = rd_pulses - r0;
  endtask

  int lat, we_p, rd_p;
  logic [31:0] rdata;
  logic err, io;
  bit addr_ok, stable_ok, idle_ok, tmo;

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err, rsp_io, mem_rden2, mem_we2, mem_sign} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {rsp_valid, rsp_err, rsp_io, mem_rden2, mem_we2, mem_sign}); else n_pass++;
    n_checks++; if ({rsp_rdata, mem_addr2, mem_din2, mem_size} !== 98'b0)
      $display("FAIL reset_data: got %h/%h/%h/%h want 0", rsp_rdata, mem_addr2, mem_din2, mem_size); else n_pass++;
  endtask

  task automatic test_store_load();
    run_req(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    ref_store(32'h100, 32'hDEADBEEF, 2'd2);
    n_checks++; if (lat !== 1) $display("FAIL store_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (we_p !== 1 || rd_p !== 0) $display("FAIL store_pulses: got we=%0d rd=%0d want we=1 rd=0", we_p, rd_p); else n_pass++;
    n_checks++; if ({rdata, err, io} !== 34'b0) $display("FAIL store_rsp: got %h err=%b io=%b want 0", rdata, err, io); else n_pass++;
    n_checks++; if (!idle_ok) $display("FAIL store_idle: got busy want idle"); else n_pass++;
    run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL load_word: got %h want deadbeef", rdata); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (we_p !== 0 || rd_p !== 1) $display("FAIL load_pulses: got we=%0d rd=%0d want we=0 rd=1", we_p, rd_p); else n_pass++;
  endtask

  task automatic test_signed_byte();
    run_req(1'b1, 32'h104, 32'h000080FF, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    ref_store(32'h104, 32'h000080FF, 2'd2);
    run_req(1'b0, 32'h105, 32'h0, 2'd0, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (rdata !== 32'hFFFFFF80) $display("FAIL signed_byte: got %h want ffffff80", rdata); else n_pass++;
    n_checks++; if (!addr_ok) $display("FAIL signed_byte_addr_hold: got moving want 00000105 held"); else n_pass++;
    run_req(1'b0, 32'h105, 32'h0, 2'd0, 1'b1, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (rdata !== 32'h00000080) $display("FAIL unsigned_byte: got %h want 00000080", rdata); else n_pass++;
  endtask

  task automatic test_backpressure();
    run_req(1'b0, 32'h104, 32'h0, 2'd1, 1'b0, 5, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (rdata !== 32'hFFFF80FF) $display("FAIL bp_data: got %h want ffff80ff", rdata); else n_pass++;
    n_checks++; if (!stable_ok) $display("FAIL bp_stable: got unstable response want stable"); else n_pass++;
    n_checks++; if (!idle_ok) $display("FAIL bp_release: got busy want idle"); else n_pass++;
  endtask

  task automatic test_mmio();
    run_req(1'b0, 32'h0001_1000, 32'h0, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (io !== 1'b1) $display("FAIL mmio_hi: got %b want 1", io); else n_pass++;
    run_req(1'b0, 32'h0000_FFFC, 32'h0, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (io !== 1'b0) $display("FAIL mmio_lo: got %b want 0", io); else n_pass++;
    run_req(1'b1, 32'h0001_0000, 32'h5, 2'd0, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (io !== 1'b1) $display("FAIL mmio_base: got %b want 1", io); else n_pass++;
  endtask

  task automatic test_misalign();
    run_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
`ifdef OTTER_LSU_MISALIGN_TRAP_EN
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0) $display("FAIL misalign_err: got err=%b data=%h want err=1 data=0", err, rdata); else n_pass++;
    n_checks++; if (rd_p !== 0 || lat !== 0) $display("FAIL misalign_noissue: got rd=%0d lat=%0d want 0/0", rd_p, lat); else n_pass++;
    run_req(1'b1, 32'h200, 32'h1, 2'd3, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (err !== 1'b1 || we_p !== 0) $display("FAIL size3_reject: got err=%b we=%0d want 1/0", err, we_p); else n_pass++;
`else
    n_checks++; if (err !== 1'b0) $display("FAIL misalign_err: got %b want 0", err); else n_pass++;
    n_checks++; if (rd_p !== 1 || lat !== 2) $display("FAIL misalign_issue: got rd=%0d lat=%0d want 1/2", rd_p, lat); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      run_req(1'b1, 32'h3C0 + 32'(4 * k), 32'(k), 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
      ref_store(32'h3C0 + 32'(4 * k), 32'(k), 2'd2);
    end
    n_checks++; if (cyc - t0 !== 12) $display("FAIL b2b_store_cycles: got %0d want 12", cyc - t0); else n_pass++;
    t0 = cyc;
    for (int k = 0; k < 4; k++)
      run_req(1'b0, 32'h3C0 + 32'(4 * k), 32'h0, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
    n_checks++; if (cyc - t0 !== 16) $display("FAIL b2b_load_cycles: got %0d want 16", cyc - t0); else n_pass++;
    n_checks++; if (rdata !== 32'd3) $display("FAIL b2b_last_data: got %h want 3", rdata); else n_pass++;
  endtask

  task automatic test_latency3();
    int l1, l3;
    logic [31:0] d3;
    l1 = -1; l3 = -1; d3 = '0;
    req_we = 1'b0; req_addr = 32'h104; req_size = 2'd2; req_sign = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid3 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (l1 < 0 && rsp_valid) l1 = n;
      if (l3 < 0 && rsp_valid_3) begin l3 = n; d3 = rsp_rdata_3; end
    end
    n_checks++; if (l3 - l1 !== 2) $display("FAIL lat3_delta: got %0d want 2", l3 - l1); else n_pass++;
    n_checks++; if (l3 !== 4) $display("FAIL lat3_abs: got %0d want 4", l3); else n_pass++;
    n_checks++; if (d3 !== exp_load(32'h104, 2'd2, 1'b0)) $display("FAIL lat3_data: got %h want %h", d3, exp_load(32'h104, 2'd2, 1'b0)); else n_pass++;
  endtask

  task automatic test_random();
    logic        we, sg;
    logic [1:0]  sz;
    logic [31:0] a, d, exp;
    int          off;
    for (int k = 0; k < 64; k++) begin
      d = $urandom;
      run_req(1'b1, 32'h200 + 32'(4 * k), d, 2'd2, 1'b0, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
      ref_store(32'h200 + 32'(4 * k), d, 2'd2);
    end
    for (int k = 0; k < 60; k++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 2));
      off = (sz == 2'd0) ? int'($urandom_range(0, 3)) : (sz == 2'd1) ? int'($urandom_range(0, 2)) : 0;
      a   = 32'h200 + 32'(4 * $urandom_range(0, 63)) + 32'(off);
      d   = $urandom;
      sg  = 1'($urandom_range(0, 1));
      exp = we ? 32'h0 : exp_load(a, sz, sg);
      run_req(we, a, d, sz, sg, 0, lat, rdata, err, io, we_p, rd_p, addr_ok, stable_ok, idle_ok, tmo);
      if (we) ref_store(a, d, sz);
      n_checks++; if (tmo) $display("FAIL rnd_timeout: op %0d got no response want response", k); else n_pass++;
      n_checks++; if (rdata !== exp) $display("FAIL rnd_data: op %0d addr %h sz %0d sign %b got %h want %h", k, a, sz, sg, rdata, exp); else n_pass++;
      n_checks++; if (lat !== (we ? 1 : 2)) $display("FAIL rnd_latency: op %0d got %0d want %0d", k, lat, we ? 1 : 2); else n_pass++;
      n_checks++; if (we_p !== int'(we) || rd_p !== int'(!we)) $display("FAIL rnd_pulses: op %0d got we=%0d rd=%0d want we=%0d rd=%0d", k, we_p, rd_p, we, !we); else n_pass++;
      n_checks++; if (!addr_ok || !idle_ok) $display("FAIL rnd_hold_idle: op %0d got addr_ok=%b idle=%b want 1/1", k, addr_ok, idle_ok); else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    int  w0;
    bit  seen;
    seen = 1'b0;
    w0 = we_pulses;
    req_we = 1'b1; req_addr = 32'h300; req_wdata = 32'h12345678; req_size = 2'd2; req_sign = 1'b0;
    rsp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (mem_we2 !== 1'b1) $display("FAIL midop_issue: got we=%b want 1", mem_we2); else n_pass++;
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    n_checks++; if ({mem_we2, rsp_valid, req_ready} !== 3'b001)
      $display("FAIL midop_abort: got we/valid/ready=%b want 001", {mem_we2, rsp_valid, req_ready}); else n_pass++;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++; if (seen || we_pulses !== w0) $display("FAIL midop_silent: got rsp=%b writes=%0d want 0/0", seen, we_pulses - w0); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_words[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_signed_byte();
    test_backpressure();
    test_mmio();
    test_misalign();
    test_back_to_back();
    test_latency3();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
